// File: rtl/fx2_fifo_arbiter_pkg.sv
// Shared types and constants for the FX2LP slave-FIFO arbiter.
package fx2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    XFER
  } state_t;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  localparam int unsigned RD  = 0;
  localparam int unsigned WR0 = 1;
  localparam int unsigned WR1 = 2;

  function automatic logic [1:0] owner_idx(input logic [2:0] onehot);
    if (onehot[WR1])      return 2'd2;
    else if (onehot[WR0]) return 2'd1;
    else                  return 2'd0;
  endfunction

endpackage

// File: rtl/fx2_fifo_arbiter_if.sv
// Client-side handshake bundle: one EP2 reader and two EP6 writers.
interface fx2_fifo_arbiter_if #(
  parameter int DW = 16
) ();

  logic          rd_req;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [1:0]    wr_req;
  logic [1:0]    wr_valid;
  logic [DW-1:0] wr_data0;
  logic [DW-1:0] wr_data1;
  logic [1:0]    wr_ack;
  logic [2:0]    grant;

  modport master (
    output rd_req, rd_ready, wr_req, wr_valid, wr_data0, wr_data1,
    input  rd_valid, rd_data, wr_ack, grant
  );

  modport slave (
    input  rd_req, rd_ready, wr_req, wr_valid, wr_data0, wr_data1,
    output rd_valid, rd_data, wr_ack, grant
  );

endinterface

// File: rtl/fx2_fifo_arbiter_rr_arb3.sv
// 3-way round-robin picker; the pointer moves past the owner on each advance pulse.
module rr_arb3
  import fx2_pkg::*;
(
  input  logic       CLKOUT,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       advance,
  input  logic [1:0] owner,
  output logic [2:0] next_grant,
  output logic       any_req
);

  logic [1:0] ptr;

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'(RD);
    end else if (advance) begin
      ptr <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    end
  end

  always_comb begin
    int unsigned idx;
    next_grant = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = (32'(ptr) + k) % 3;
      if (next_grant == '0 && req[idx]) next_grant[idx] = 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fx2_fifo_arbiter.sv
// FX2LP slave-FIFO bus owner: arbitrates one EP2 reader and two EP6 writers
// over the shared FDATA/FIFOADR/strobe pins.
module fx2_fifo_arbiter
  import fx2_pkg::*;
#(
  parameter int DW       = 16,
  parameter int MAXBURST = 8
) (
  input  logic                CLKOUT,
  input  logic                rst_n,
  input  logic                FLAGA,
  input  logic                FLAGD,
  output logic                SLRD,
  output logic                SLWR,
  output logic                SLOE,
  output logic                IFCLK,
  output logic [1:0]          FIFOADR,
  inout  wire  [DW-1:0]       FDATA,
  fx2_fifo_arbiter_if.slave   cl
);

  state_t        state, state_nx;
  logic [2:0]    grant_q;
  logic [1:0]    fifoadr_q;
  logic [7:0]    cnt_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;

  logic [2:0]    next_grant;
  logic          any_req;
  logic          advance;
  logic [1:0]    owner;
  logic          rd_own, wr_own;
  logic          wr_v;
  logic [DW-1:0] wr_d;
  logic          rd_stb, wr_stb, stb;
  logic          own_req, own_flag, last;

  rr_arb3 u_arb (
    .CLKOUT     (CLKOUT),
    .rst_n      (rst_n),
    .req        ({cl.wr_req, cl.rd_req}),
    .advance    (advance),
    .owner      (owner),
    .next_grant (next_grant),
    .any_req    (any_req)
  );

  assign owner  = owner_idx(grant_q);
  assign rd_own = grant_q[RD];
  assign wr_own = grant_q[WR0] | grant_q[WR1];
  assign wr_v   = grant_q[WR1] ? cl.wr_valid[1] : cl.wr_valid[0];
  assign wr_d   = grant_q[WR1] ? cl.wr_data1 : cl.wr_data0;

  // Strobes come from registered state gated by live flags/handshakes, so a
  // dropped flag or client stall suppresses the strobe in that very cycle.
  assign rd_stb   = (state == XFER) && rd_own && FLAGA && cl.rd_ready;
  assign wr_stb   = (state == XFER) && wr_own && FLAGD && wr_v;
  assign stb      = rd_stb | wr_stb;
  assign own_req  = |(grant_q & {cl.wr_req, cl.rd_req});
  assign own_flag = rd_own ? FLAGA : FLAGD;
  assign last     = stb && ((cnt_q + 8'd1) == 8'(MAXBURST));

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    unique case (state)
      IDLE: if (any_req) state_nx = ADDR;
      ADDR: state_nx = XFER;
      XFER: begin
        if (last || !own_req || !own_flag) begin
          state_nx = IDLE;
          advance  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_q    <= '0;
      fifoadr_q  <= EP2_ADDR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_valid_q <= rd_stb;
      if (rd_stb) rd_data_q <= FDATA;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_q   <= next_grant;
            fifoadr_q <= next_grant[RD] ? EP2_ADDR : EP6_ADDR;
          end
        end
        ADDR: cnt_q <= '0;
        XFER: begin
          if (stb) cnt_q <= cnt_q + 8'd1;
          if (advance) grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign SLRD        = ~rd_stb;
  assign SLWR        = ~wr_stb;
  assign SLOE        = ~rd_own;
  assign IFCLK       = ~CLKOUT;
  assign FIFOADR     = fifoadr_q;
  assign FDATA       = wr_own ? wr_d : {DW{1'bz}};
  assign cl.wr_ack   = {grant_q[WR1] & wr_stb, grant_q[WR0] & wr_stb};
  assign cl.grant    = grant_q;
  assign cl.rd_valid = rd_valid_q;
  assign cl.rd_data  = rd_data_q;

endmodule
